// File: rtl/fft_overlap_add_pkg.sv
// Shared definitions for the overlap-add output stage and the FFT input buffer.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
// Contents: the accumulator-clear/run state enum and the OUT_SHIFT / ACC_WIDTH derivations.
package fft_overlap_add_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } ola_state_t;

    // Each output location receives N/H overlapping contributions, so dividing
    // by N/H restores unity gain.
    function automatic int ola_out_shift(input int fft_length, input int hop);
        return $clog2(fft_length / hop);
    endfunction

    // Enough headroom to hold the sum of N/H full-scale samples.
    function automatic int ola_acc_width(input int data_width, input int out_shift);
        return data_width + out_shift;
    endfunction

endpackage

// File: rtl/fft_overlap_add_acc_ram.sv
// Simple dual-port accumulator RAM: one write port, one registered read port.
// Latency: read data valid one cycle after rd_en/rd_addr are sampled.
// Backpressure: none; both ports accept an access every cycle.
// Ports: clk; wr_en/wr_addr/wr_data write port; rd_en/rd_addr read request; rd_data registered read data.
module fft_overlap_add_acc_ram #(
    parameter int DEPTH      = 2048,
    parameter int WIDTH      = 18,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fft_overlap_add.sv
// Overlap-add of IFFT frames: accumulates every frame into an N-entry ring and emits H finished samples per frame.
// Latency: a sample presented in cycle t produces o_valid/o_data (and o_frame_error) in cycle t+2.
// Backpressure: none; input gaps become o_valid bubbles, inputs are dropped while o_busy (accumulator clear).
// Ports: i_clk, i_reset (sync, active high); i_data/i_valid/i_last IFFT sample stream;
//        o_data/o_valid reconstructed samples; o_busy clearing; o_frame_error framing-mismatch pulse.
module fft_overlap_add
    import fft_overlap_add_pkg::*;
#(
    parameter int DATA_WIDTH          = 16,
    parameter int FFT_LENGTH          = 2048,
    parameter int NEW_SAMPLES_PER_FFT = 512,
    parameter int OUT_SHIFT           = ola_out_shift(FFT_LENGTH, NEW_SAMPLES_PER_FFT)
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    input  logic                  i_last,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_busy,
    output logic                  o_frame_error
);

    localparam int ACC_WIDTH = ola_acc_width(DATA_WIDTH, OUT_SHIFT);
    localparam int SUM_WIDTH = ACC_WIDTH + 1;
    localparam int AW        = $clog2(FFT_LENGTH);

    localparam logic [AW-1:0] LAST_K = AW'(FFT_LENGTH - 1);
    localparam logic [AW-1:0] HOP    = AW'(NEW_SAMPLES_PER_FFT);
    localparam logic [AW-1:0] ONE    = AW'(1);

    localparam logic [ACC_WIDTH-1:0]  ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0]  ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] OUT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] OUT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    // Control state
    ola_state_t    state;
    ola_state_t    state_nxt;
    logic [AW-1:0] clr_addr;
    logic [AW-1:0] clr_addr_nxt;
    logic          busy;

    // Frame position
    logic [AW-1:0] base;
    logic [AW-1:0] k;
    logic          accept;
    logic          frame_end;
    logic [AW-1:0] rd_addr;

    // Stage 1: RAM read data arrives alongside the registered sample
    logic                  s1_vld;
    logic [AW-1:0]         s1_addr;
    logic [DATA_WIDTH-1:0] s1_data;
    logic                  s1_is_out;
    logic                  s1_err;
    logic [ACC_WIDTH-1:0]  acc_rd;

    // Stage 1 arithmetic
    logic signed [SUM_WIDTH-1:0] sum;
    logic signed [SUM_WIDTH-1:0] shifted;
    logic [ACC_WIDTH-1:0]        acc_wb;
    logic [DATA_WIDTH-1:0]       out_sat;

    // RAM write port (shared between clear sweep and accumulate)
    logic                 ram_we;
    logic [AW-1:0]        ram_waddr;
    logic [ACC_WIDTH-1:0] ram_wdata;

    assign accept    = i_valid && (state == ST_RUN);
    assign rd_addr   = base + k;
    // A frame always ends at k = N-1; an early i_last ends it too (and flags an error).
    assign frame_end = (k == LAST_K) || i_last;
    assign o_busy    = busy;

    // ------------------------------------------------------------------
    // FSM: clear sweep over the whole RAM, then run forever
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
        end else begin
            state    <= state_nxt;
            clr_addr <= clr_addr_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        clr_addr_nxt = clr_addr;
        busy         = 1'b0;
        ram_we       = 1'b0;
        ram_waddr    = s1_addr;
        ram_wdata    = '0;
        case (state)
            ST_CLEAR: begin
                busy         = 1'b1;
                ram_we       = 1'b1;
                ram_waddr    = clr_addr;
                ram_wdata    = '0;
                clr_addr_nxt = clr_addr + ONE;
                if (clr_addr == LAST_K) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                ram_we    = s1_vld;
                ram_waddr = s1_addr;
                // Output locations are final: zero them so the next pass starts clean.
                ram_wdata = s1_is_out ? '0 : acc_wb;
            end
            default: begin
                state_nxt = ST_CLEAR;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Accumulator RAM
    // ------------------------------------------------------------------
    fft_overlap_add_acc_ram #(
        .DEPTH      (FFT_LENGTH),
        .WIDTH      (ACC_WIDTH),
        .ADDR_WIDTH (AW)
    ) u_acc_ram (
        .clk     (i_clk),
        .wr_en   (ram_we),
        .wr_addr (ram_waddr),
        .wr_data (ram_wdata),
        .rd_en   (accept),
        .rd_addr (rd_addr),
        .rd_data (acc_rd)
    );

    // ------------------------------------------------------------------
    // Stage 0: accept sample, advance frame position
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            k      <= '0;
            base   <= '0;
            s1_vld <= 1'b0;
        end else begin
            s1_vld <= accept;
            if (accept) begin
                if (frame_end) begin
                    k    <= '0;
                    base <= base + HOP;
                end else begin
                    k <= k + ONE;
                end
            end
        end
    end

    // Payload registers need no reset: they are qualified by s1_vld.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            s1_addr   <= rd_addr;
            s1_data   <= i_data;
            s1_is_out <= (k < HOP);
            s1_err    <= (i_last != (k == LAST_K));
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: add, write back, scale and saturate
    // ------------------------------------------------------------------
    always_comb begin
        sum = {acc_rd[ACC_WIDTH-1], acc_rd}
            + {{(SUM_WIDTH-DATA_WIDTH){s1_data[DATA_WIDTH-1]}}, s1_data};

        // Write-back clamps instead of wrapping; only reachable when OUT_SHIFT
        // is configured below log2(N/H) and the accumulator lacks headroom.
        if (sum[SUM_WIDTH-1] != sum[SUM_WIDTH-2]) begin
            acc_wb = sum[SUM_WIDTH-1] ? ACC_MIN : ACC_MAX;
        end else begin
            acc_wb = sum[ACC_WIDTH-1:0];
        end

        shifted = sum >>> OUT_SHIFT;
        // In range iff all bits from the output sign bit upward agree.
        if ((&shifted[SUM_WIDTH-1:DATA_WIDTH-1]) || !(|shifted[SUM_WIDTH-1:DATA_WIDTH-1])) begin
            out_sat = shifted[DATA_WIDTH-1:0];
        end else begin
            out_sat = shifted[SUM_WIDTH-1] ? OUT_MIN : OUT_MAX;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_valid       <= 1'b0;
            o_data        <= '0;
            o_frame_error <= 1'b0;
        end else begin
            o_valid       <= s1_vld && s1_is_out;
            o_frame_error <= s1_vld && s1_err;
            if (s1_vld && s1_is_out) begin
                o_data <= out_sat;
            end
        end
    end

endmodule

// File: tb/tb_fft_overlap_add.sv
module tb_fft_overlap_add;

    localparam int N     = 8;
    localparam int H     = 2;
    localparam int SHIFT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT: N=8, H=2, OUT_SHIFT=2
    logic        i_reset, i_valid, i_last;
    logic [15:0] i_data;
    logic [15:0] o_data;
    logic        o_valid, o_busy, o_frame_error;

    // Saturation DUT: N=8, H=2, OUT_SHIFT=0
    logic        s_reset, s_valid, s_last;
    logic [15:0] s_data;
    logic [15:0] s_data_o;
    logic        s_valid_o, s_busy, s_err;

    fft_overlap_add #(
        .DATA_WIDTH(16), .FFT_LENGTH(N), .NEW_SAMPLES_PER_FFT(H), .OUT_SHIFT(SHIFT)
    ) dut (
        .i_clk(clk), .i_reset(i_reset), .i_data(i_data), .i_valid(i_valid), .i_last(i_last),
        .o_data(o_data), .o_valid(o_valid), .o_busy(o_busy), .o_frame_error(o_frame_error)
    );

    fft_overlap_add #(
        .DATA_WIDTH(16), .FFT_LENGTH(N), .NEW_SAMPLES_PER_FFT(H), .OUT_SHIFT(0)
    ) dut_sat (
        .i_clk(clk), .i_reset(s_reset), .i_data(s_data), .i_valid(s_valid), .i_last(s_last),
        .o_data(s_data_o), .o_valid(s_valid_o), .o_busy(s_busy), .o_frame_error(s_err)
    );

    typedef struct {
        logic        vld;
        logic [15:0] dat;
        logic        err;
        int          cyc;
    } exp_t;

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic        l;
        logic        r;
    } stim_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;

    // Reference overlap-add model
    int m_acc[N];
    int m_base;
    int m_k;

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_acc[i] = 0;
        m_base = 0;
        m_k    = 0;
        sb.delete();
    endtask

    // Called while the sample is being presented (cycle cyc); results are due in cycle cyc+2.
    task automatic model_push(input logic [15:0] d, input logic last);
        int   a, s, o;
        logic is_out, err;
        exp_t e;
        a      = (m_base + m_k) % N;
        s      = m_acc[a] + int'($signed(d));
        o      = 0;
        is_out = (m_k < H);
        err    = (last != (m_k == N - 1));
        if (is_out) begin
            o = s >>> SHIFT;
            if (o > 32767)  o = 32767;
            if (o < -32768) o = -32768;
            m_acc[a] = 0;
        end else begin
            m_acc[a] = s;
        end
        if (is_out || err) begin
            e.vld = is_out;
            e.dat = 16'(o);
            e.err = err;
            e.cyc = cyc + 2;
            sb.push_back(e);
        end
        if (last || m_k == N - 1) begin
            m_k    = 0;
            m_base = (m_base + H) % N;
        end else begin
            m_k++;
        end
    endtask

    // Present inputs for one cycle; afterwards cyc names the cycle now visible on the outputs.
    task automatic tick(input logic v, input logic [15:0] d, input logic l, input logic r);
        i_valid = v;
        i_data  = d;
        i_last  = l;
        i_reset = r;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        int busy_cycles;
        tick(1'b0, 16'd0, 1'b0, 1'b1);
        model_reset();
        vectors++;
        if (o_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b, required 0", o_valid); end
        vectors++;
        if (o_data !== 16'd0) begin miscompares++; $display("FAIL reset_data: got %h, required 0000", o_data); end
        vectors++;
        if (o_frame_error !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b, required 0", o_frame_error); end
        vectors++;
        if (o_busy !== 1'b1) begin miscompares++; $display("FAIL reset_busy: got %b, required 1", o_busy); end
        busy_cycles = 1;
        for (int i = 0; i < 20 && o_busy === 1'b1; i++) begin
            tick(1'b0, 16'd0, 1'b0, 1'b0);
            if (o_busy === 1'b1) busy_cycles++;
        end
        vectors++;
        if (busy_cycles != N) begin miscompares++; $display("FAIL reset_busy_len: got %0d cycles, required %0d", busy_cycles, N); end
    endtask

    task automatic test_constant_wrap();
        stim_t st[$];
        int    f;
        for (int j = 0; j < 10 * N; j++) st.push_back('{1'b1, 16'd4, ((j % N) == N - 1), 1'b0});
        repeat (3) st.push_back('{1'b0, 16'd0, 1'b0, 1'b0});
        f = 0;
        foreach (st[i]) begin
            if (st[i].v) model_push(st[i].d, st[i].l);
            tick(st[i].v, st[i].d, st[i].l, st[i].r);
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                vectors++; miscompares++;
                $display("FAIL const_missing: cycle %0d got nothing, required valid=%b data=%0d err=%b", sb[0].cyc, sb[0].vld, $signed(sb[0].dat), sb[0].err);
                sb.delete(0);
            end
            if (o_valid || o_frame_error) begin
                vectors++;
                if (sb.size() == 0 || sb[0].cyc != cyc) begin
                    miscompares++;
                    $display("FAIL const_unexpected: cycle %0d got valid=%b data=%0d err=%b, required none", cyc, o_valid, $signed(o_data), o_frame_error);
                end else begin
                    if (o_valid !== sb[0].vld || (sb[0].vld && o_data !== sb[0].dat) || o_frame_error !== sb[0].err) begin
                        miscompares++;
                        $display("FAIL const_output: cycle %0d got valid=%b data=%0d err=%b, required valid=%b data=%0d err=%b", cyc, o_valid, $signed(o_data), o_frame_error, sb[0].vld, $signed(sb[0].dat), sb[0].err);
                    end
                    sb.delete(0);
                end
            end
            if (st[i].v && st[i].l) begin
                vectors++;
                if (dut.base !== 3'(((f + 1) * H) % N)) begin
                    miscompares++;
                    $display("FAIL const_base: frame %0d got base %0d, required %0d", f, dut.base, ((f + 1) * H) % N);
                end
                f++;
            end
        end
    endtask

    task automatic test_frame_error();
        stim_t st[$];
        int    errs;
        for (int j = 0; j < 6; j++) st.push_back('{1'b1, 16'd4, (j == 5), 1'b0});
        for (int j = 0; j < N; j++) st.push_back('{1'b1, 16'd4, (j == N - 1), 1'b0});
        repeat (3) st.push_back('{1'b0, 16'd0, 1'b0, 1'b0});
        errs = 0;
        foreach (st[i]) begin
            if (st[i].v) model_push(st[i].d, st[i].l);
            tick(st[i].v, st[i].d, st[i].l, st[i].r);
            if (o_frame_error === 1'b1) errs++;
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                vectors++; miscompares++;
                $display("FAIL ferr_missing: cycle %0d got nothing, required valid=%b data=%0d err=%b", sb[0].cyc, sb[0].vld, $signed(sb[0].dat), sb[0].err);
                sb.delete(0);
            end
            if (o_valid || o_frame_error) begin
                vectors++;
                if (sb.size() == 0 || sb[0].cyc != cyc) begin
                    miscompares++;
                    $display("FAIL ferr_unexpected: cycle %0d got valid=%b data=%0d err=%b, required none", cyc, o_valid, $signed(o_data), o_frame_error);
                end else begin
                    if (o_valid !== sb[0].vld || (sb[0].vld && o_data !== sb[0].dat) || o_frame_error !== sb[0].err) begin
                        miscompares++;
                        $display("FAIL ferr_output: cycle %0d got valid=%b data=%0d err=%b, required valid=%b data=%0d err=%b", cyc, o_valid, $signed(o_data), o_frame_error, sb[0].vld, $signed(sb[0].dat), sb[0].err);
                    end
                    sb.delete(0);
                end
            end
        end
        vectors++;
        if (errs != 1) begin miscompares++; $display("FAIL ferr_count: got %0d error pulses, required 1", errs); end
    endtask

    task automatic test_reset_midframe();
        stim_t st[$];
        int    busy_left;
        for (int j = 0; j < 3; j++) st.push_back('{1'b1, 16'd4, 1'b0, 1'b0});
        st.push_back('{1'b1, 16'd4, 1'b0, 1'b1});
        for (int j = 0; j < N; j++) st.push_back('{1'b1, 16'd4, 1'b1, 1'b0});
        for (int j = 0; j < N; j++) st.push_back('{1'b1, 16'd4, (j == N - 1), 1'b0});
        repeat (3) st.push_back('{1'b0, 16'd0, 1'b0, 1'b0});
        busy_left = 0;
        foreach (st[i]) begin
            if (st[i].r) model_reset();
            else if (st[i].v && busy_left == 0) model_push(st[i].d, st[i].l);
            tick(st[i].v, st[i].d, st[i].l, st[i].r);
            if (st[i].r) busy_left = N;
            else if (busy_left > 0) busy_left--;
            if (st[i].r) begin
                vectors++;
                if (o_valid !== 1'b0 || o_data !== 16'd0) begin
                    miscompares++;
                    $display("FAIL midrst_outputs: got valid=%b data=%h, required valid=0 data=0000", o_valid, o_data);
                end
            end
            vectors++;
            if (o_busy !== (busy_left > 0)) begin
                miscompares++;
                $display("FAIL midrst_busy: cycle %0d got %b, required %b", cyc, o_busy, (busy_left > 0));
            end
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                vectors++; miscompares++;
                $display("FAIL midrst_missing: cycle %0d got nothing, required valid=%b data=%0d err=%b", sb[0].cyc, sb[0].vld, $signed(sb[0].dat), sb[0].err);
                sb.delete(0);
            end
            if (o_valid || o_frame_error) begin
                vectors++;
                if (sb.size() == 0 || sb[0].cyc != cyc) begin
                    miscompares++;
                    $display("FAIL midrst_unexpected: cycle %0d got valid=%b data=%0d err=%b, required none", cyc, o_valid, $signed(o_data), o_frame_error);
                end else begin
                    if (o_valid !== sb[0].vld || (sb[0].vld && o_data !== sb[0].dat) || o_frame_error !== sb[0].err) begin
                        miscompares++;
                        $display("FAIL midrst_output: cycle %0d got valid=%b data=%0d err=%b, required valid=%b data=%0d err=%b", cyc, o_valid, $signed(o_data), o_frame_error, sb[0].vld, $signed(sb[0].dat), sb[0].err);
                    end
                    sb.delete(0);
                end
            end
        end
    endtask

    task automatic test_random_gaps();
        stim_t st[$];
        for (int j = 0; j < 6 * N; j++) begin
            while ($urandom_range(1) == 0) st.push_back('{1'b0, 16'($urandom), 1'b0, 1'b0});
            st.push_back('{1'b1, 16'($urandom), ((j % N) == N - 1), 1'b0});
        end
        repeat (3) st.push_back('{1'b0, 16'd0, 1'b0, 1'b0});
        foreach (st[i]) begin
            if (st[i].v) model_push(st[i].d, st[i].l);
            tick(st[i].v, st[i].d, st[i].l, st[i].r);
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                vectors++; miscompares++;
                $display("FAIL rand_missing: cycle %0d got nothing, required valid=%b data=%0d err=%b", sb[0].cyc, sb[0].vld, $signed(sb[0].dat), sb[0].err);
                sb.delete(0);
            end
            if (o_valid || o_frame_error) begin
                vectors++;
                if (sb.size() == 0 || sb[0].cyc != cyc) begin
                    miscompares++;
                    $display("FAIL rand_unexpected: cycle %0d got valid=%b data=%0d err=%b, required none", cyc, o_valid, $signed(o_data), o_frame_error);
                end else begin
                    if (o_valid !== sb[0].vld || (sb[0].vld && o_data !== sb[0].dat) || o_frame_error !== sb[0].err) begin
                        miscompares++;
                        $display("FAIL rand_output: cycle %0d got valid=%b data=%0d err=%b, required valid=%b data=%0d err=%b", cyc, o_valid, $signed(o_data), o_frame_error, sb[0].vld, $signed(sb[0].dat), sb[0].err);
                    end
                    sb.delete(0);
                end
            end
        end
    endtask

    // OUT_SHIFT=0 instance: full-scale inputs must pin the output at the rail.
    task automatic test_saturation();
        logic [15:0] val;
        int          outs;
        for (int p = 0; p < 2; p++) begin
            val     = (p == 0) ? 16'h7FFF : 16'h8000;
            s_valid = 1'b0;
            s_last  = 1'b0;
            s_reset = 1'b1;
            @(posedge clk); cyc++; #1;
            s_reset = 1'b0;
            for (int w = 0; w < 20 && s_busy === 1'b1; w++) begin
                @(posedge clk); cyc++; #1;
            end
            vectors++;
            if (s_busy !== 1'b0) begin miscompares++; $display("FAIL sat_clear_timeout: busy=%b, required 0", s_busy); end
            outs = 0;
            for (int j = 0; j < 4 * N + 3; j++) begin
                s_valid = (j < 4 * N);
                s_data  = val;
                s_last  = (j < 4 * N) && ((j % N) == N - 1);
                @(posedge clk); cyc++; #1;
                if (s_valid_o === 1'b1) begin
                    outs++;
                    vectors++;
                    if (s_data_o !== val) begin
                        miscompares++;
                        $display("FAIL sat_value: output %0d got %h, required %h", outs, s_data_o, val);
                    end
                end
                vectors++;
                if (s_err !== 1'b0) begin miscompares++; $display("FAIL sat_err: got %b, required 0", s_err); end
            end
            s_valid = 1'b0;
            s_last  = 1'b0;
            vectors++;
            if (outs != 8) begin miscompares++; $display("FAIL sat_count: got %0d outputs, required 8", outs); end
        end
    endtask

    initial begin
        i_reset = 1'b1;
        i_valid = 1'b0;
        i_data  = 16'd0;
        i_last  = 1'b0;
        s_reset = 1'b1;
        s_valid = 1'b0;
        s_data  = 16'd0;
        s_last  = 1'b0;
        model_reset();
        test_reset();
        test_constant_wrap();
        test_frame_error();
        test_reset_midframe();
        test_random_gaps();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fft_overlap_add.md
FFT_OVERLAP_ADD -- requirements
Module: fft_overlap_add

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 16, signed sample width; FFT_LENGTH, 2048, frame length N, power of two, >= 8; NEW_SAMPLES_PER_FFT, 512, hop H, power of two, H <= N/2; OUT_SHIFT, log2(N/H), arithmetic right shift applied to each output.
REQ-002 i_clk  in  1  sole clock; all logic on rising edge.
REQ-003 i_reset  in  1  synchronous, active-high reset.
REQ-004 i_data  in  DATA_WIDTH  signed IFFT output sample.
REQ-005 i_valid  in  1  i_data valid this cycle; there is no back-pressure.
REQ-006 i_last  in  1  marks the last sample of an input frame.
REQ-007 o_data  out  DATA_WIDTH  reconstructed signed time-domain sample.
REQ-008 o_valid  out  1  o_data valid this cycle.
REQ-009 o_busy  out  1  high while the accumulator is being cleared; inputs are ignored.
REQ-010 o_frame_error  out  1  one-cycle pulse on a framing mismatch.

Function
REQ-011 The block SHALL hold an accumulator RAM of N entries, ACC_WIDTH = DATA_WIDTH + OUT_SHIFT bits, with a base pointer (log2 N bits, wraps mod N) and a sample counter k (0..N-1).
REQ-012 The FSM SHALL have two states: CLEAR (write 0 to address 0..N-1, one per cycle, o_busy=1) -> RUN after address N-1 is written.
REQ-013 In RUN, each accepted sample k SHALL address acc[(base+k) mod N].
REQ-014 For k < H: sum = acc + i_data; output sum; write 0 back (the location is final).
REQ-015 For k >= H: write acc + i_data back; no output.
REQ-016 Output value SHALL be sum >>> OUT_SHIFT, saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-017 Latency SHALL be exactly 2 cycles from the accepting i_valid edge to o_valid (RAM read stage, then add/write/output register); o_valid is never high for two samples of the same input.
REQ-018 Input gaps (i_valid=0) SHALL stall nothing but insert o_valid=0 bubbles; back-to-back frames at one sample per cycle SHALL be sustained.
REQ-019 No read-after-write bypass is required: same-address accesses are at least N-H >= 4 samples apart.
REQ-020 End of frame: i_last at k=N-1 -> k=0, base += H.
REQ-021 Mismatch: i_last at k<N-1, or k=N-1 with i_last=0 -> frame still ends on that sample (k=0, base += H), o_frame_error=1 for one cycle with the same 2-cycle latency.
REQ-022 The first N/H-1 frames after CLEAR SHALL output partial sums (startup transient); this is accepted behaviour.

Reset
REQ-023 i_reset SHALL set o_data=0, o_valid=0, o_frame_error=0, k=0, base=0, flush pipeline valids and enter CLEAR (o_busy=1 the next cycle), including mid-frame.
REQ-024 i_valid during CLEAR SHALL be dropped with no output and no error.

Structure
REQ-025 A shared package SHALL hold the state enum (CLEAR, RUN) and the ACC_WIDTH/OUT_SHIFT derivation functions, shared with the FFT input buffer.
REQ-026 A single sub-module, overlap_acc_ram (simple dual-port, 1-cycle synchronous read, N x ACC_WIDTH), is natural; the target RTL is 120-400 lines.

Verification (N=8, H=2, DATA_WIDTH=16, OUT_SHIFT=2 unless stated)
REQ-027 Constant 4, continuous frames -> per-frame output pairs 1,1 / 2,2 / 3,3 / 4,4 thereafter, with each o_valid 2 cycles after its input.
REQ-028 OUT_SHIFT=0, all inputs 0x7FFF -> frame 0 outputs 0x7FFF, and saturated 0x7FFF from frame 1 on; all -32768 -> -32768.
REQ-029 Run 10 frames, check base wrap (0,2,4,6,0,...) and steady output 4 for constant 4 across the wrap.
REQ-030 i_last at k=5 -> o_frame_error pulses once, 2 cycles later; the next well-formed frame produces no error.
REQ-031 i_reset asserted at k=3 -> o_valid=0 next cycle, o_busy high for 8 cycles, inputs ignored; the next frame outputs 1,1 for constant 4.
REQ-032 Random i_valid gaps (50%) with random data -> o_data matches the reference overlap-add model sample-for-sample.
